// File: rtl/hidden_wires_pkg.sv
// Shared constants, state type and pointer helper for the hidden-wires packet mux.
package hidden_wires_pkg;

    localparam int HW_MAX_CH = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } mux_state_e;

    // Callers keep ptr below n, so a compare-and-clear gives (ptr+1) mod n without a divider.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/hidden_wires_rr_pick.sv
// Round-robin candidate search: first requesting channel at or after rr_ptr, wrapping.
module hidden_wires_rr_pick
    import hidden_wires_pkg::*;
#(
    parameter int NUM_CH = HW_MAX_CH,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   rr_ptr,
    output logic [CH_W-1:0]   grant,
    output logic              found
);

    always_comb begin
        grant = '0;
        found = 1'b0;
        // channels at or above the pointer take priority over the wrapped-around ones
        for (int j = 0; j < NUM_CH; j++) begin
            if (!found && req[j] && (j >= int'(rr_ptr))) begin
                found = 1'b1;
                grant = CH_W'(j);
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (!found && req[j] && (j < int'(rr_ptr))) begin
                found = 1'b1;
                grant = CH_W'(j);
            end
        end
    end

endmodule

// File: rtl/hidden_wires_pkt_mux.sv
// Merges NUM_CH packet streams onto one registered output, locking to a source for a whole packet.
// state  | meaning
// IDLE   | no packet in flight; arbitrate sop beats round-robin, discard orphan beats
// LOCKED | forwarding the owner's packet until its eop beat is accepted
module hidden_wires_pkt_mux
    import hidden_wires_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH-1:0]        in_sop,
    input  logic [NUM_CH-1:0]        in_eop,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_chan,
    output logic [15:0]              err_cnt
);

    mux_state_e        state, state_nxt;
    logic [CH_W-1:0]   owner, owner_nxt;
    logic [CH_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [CH_W-1:0]   cand, sel;
    logic              found, can_load, load, frame_err;
    logic [NUM_CH-1:0] ready_c;
    logic [DATA_W-1:0] sel_data;

    assign can_load = !out_valid || out_ready;

    hidden_wires_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .req    (in_valid & in_sop),
        .rr_ptr (rr_ptr),
        .grant  (cand),
        .found  (found)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        ready_c    = '0;
        load       = 1'b0;
        sel        = owner;
        frame_err  = 1'b0;
        case (state)
            IDLE: begin
                // orphans are drained even when the output is stalled
                ready_c   = in_valid & ~in_sop;
                frame_err = |(in_valid & ~in_sop);
                if (found && can_load) begin
                    ready_c[cand] = 1'b1;
                    load          = 1'b1;
                    sel           = cand;
                    if (in_eop[cand]) begin
                        rr_ptr_nxt = CH_W'(rr_next(32'(cand), NUM_CH));
                    end else begin
                        owner_nxt = cand;
                        state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (can_load) begin
                    ready_c[owner] = 1'b1;
                    if (in_valid[owner]) begin
                        load      = 1'b1;
                        frame_err = in_sop[owner];
                        if (in_eop[owner]) begin
                            state_nxt  = IDLE;
                            rr_ptr_nxt = CH_W'(rr_next(32'(owner), NUM_CH));
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready = ready_c & {NUM_CH{reset_n}};

    always_comb begin
        sel_data = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (sel == CH_W'(j)) sel_data = in_data[j*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_sop   <= in_sop[sel];
            out_eop   <= in_eop[sel];
            out_data  <= sel_data;
            out_chan  <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= '0;
        end else if (frame_err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: doc/hidden_wires_pkt_mux.md
HIDDEN_WIRES_PKT_MUX -- requirements
Module: hidden_wires_pkt_mux

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of input channels (2..16).
REQ-002 SHALL have parameter DATA_W, default 32, payload width in bits (8..256).
REQ-003 SHALL have parameter CH_W, default $clog2(NUM_CH), channel-id width; CH_W is derived and is not overridden.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, NUM_CH, per-channel beat valid.
REQ-007 SHALL have port in_ready, output, NUM_CH, per-channel beat accept.
REQ-008 SHALL have port in_sop, input, NUM_CH, per-channel startofpacket.
REQ-009 SHALL have port in_eop, input, NUM_CH, per-channel endofpacket.
REQ-010 SHALL have port in_data, input, NUM_CH*DATA_W, per-channel payload; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-011 SHALL have port out_valid, input/output as follows: output, 1, merged beat valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accept.
REQ-013 SHALL have ports out_sop, out_eop, output, 1 each; out_data, output, DATA_W; out_chan, output, CH_W, source channel of the beat.
REQ-014 SHALL have port err_cnt, output, 16, saturating count of framing errors.

Function
REQ-015 SHALL define beat transfer: input beat on channel i when in_valid[i] and in_ready[i] are both high at a clock edge; output beat when out_valid and out_ready are both high.
REQ-016 SHALL register the output stage: an accepted input beat appears on out_* on the next cycle, giving 1-cycle latency.
REQ-017 SHALL define can_load = !out_valid || out_ready; no input beat is accepted when can_load is low.
REQ-018 SHALL hold out_valid, out_sop, out_eop, out_data and out_chan stable while out_valid && !out_ready.
REQ-019 SHALL implement a two-state FSM, IDLE and LOCKED, with an owner register (CH_W bits) and a round-robin pointer rr_ptr (CH_W bits).
REQ-020 SHALL, in IDLE, pick as candidate the first channel at or after rr_ptr, wrapping modulo NUM_CH, with in_valid && in_sop.
REQ-021 SHALL, in IDLE, assert in_ready for the candidate only when can_load is high, with the grant taking effect in the same cycle.
REQ-022 SHALL, on an IDLE accept of a beat without eop: set owner = candidate and go to LOCKED.
REQ-023 SHALL, on an IDLE accept of a beat with sop && eop (single-beat packet): stay in IDLE and set rr_ptr = (candidate+1) mod NUM_CH.
REQ-024 SHALL, in LOCKED, assert in_ready only for owner and only while can_load is high; all other channels see in_ready=0.
REQ-025 SHALL, in LOCKED, on an accepted eop beat: go to IDLE and set rr_ptr = (owner+1) mod NUM_CH.
REQ-026 SHALL pass an sop appearing mid-packet in LOCKED through unchanged, count it as a framing error, and keep the lock.
REQ-027 SHALL, in IDLE, assert in_ready for every non-candidate channel with in_valid && !in_sop (orphan beat) regardless of can_load; such beats are discarded and never reach the output.
REQ-028 SHALL increment err_cnt by 1 per cycle in which at least one framing error (REQ-026 or REQ-027) occurs, saturating at 16'hFFFF.
REQ-029 SHALL make the wrap pointer arithmetic correct for non-power-of-two NUM_CH; rr_ptr never holds a value ≥ NUM_CH.
REQ-030 SHALL ignore in_valid on channels that are neither candidate, owner nor orphan: no accept and no state change.

Reset
REQ-031 SHALL, on reset_n low, asynchronously force: state=IDLE, owner=0, rr_ptr=0, out_valid=0, out_sop=0, out_eop=0, out_data=0, out_chan=0, err_cnt=0.
REQ-032 SHALL, on a reset mid-packet, lose the partial packet without emitting an eop; the first beat after reset is arbitrated per IDLE rules.
REQ-033 SHALL drive in_ready=0 on all channels while reset_n is low.

Structure
REQ-034 SHALL add to hidden_wires_pkg: the HW_MAX_CH=16 constant, the mux_state_e enum (IDLE, LOCKED), and a function rr_next(ptr, n) returning (ptr+1) mod n.
REQ-035 SHALL place the candidate search in one sub-module, hidden_wires_rr_pick, taking request vector and rr_ptr and returning a grant index and a found flag.

Verification
REQ-036 SHALL cover: NUM_CH=4, ch1 sends a 3-beat packet with out_ready=1 -> out_chan=1 on 3 consecutive cycles, each 1 cycle after input, sop on the first beat and eop on the third.
REQ-037 SHALL cover: ch0 and ch2 both sop at rr_ptr=0; ch0 sends 2 beats -> ch0 packet completes first, then ch2 is granted, rr_ptr=3 after ch2's eop.
REQ-038 SHALL cover: out_ready held low for 5 cycles mid-packet -> out_* stable, in_ready=0 throughout, no beat lost or duplicated.
REQ-039 SHALL cover: in IDLE, ch3 presents valid without sop -> beat discarded, err_cnt=1, out_valid remains 0.
REQ-040 SHALL cover: NUM_CH=3, single-beat packets on all channels continuously -> grant order 0,1,2,0,1,2.
REQ-041 SHALL cover: reset_n pulsed low during beat 2 of 4 -> all outputs 0 immediately, state IDLE, next sop arbitrated from rr_ptr=0.
